// File: rtl/regfile_dump_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : regfile_dump_reader
//  Brief    : Streams registers 0..NUM_REGS-1 over a valid/ready port and
//             flags snooped writes that hit an already-captured register.
//  Revision : 1.0
// ============================================================================
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    input  logic              rf_we,
    input  logic [ADDR_W-1:0] rf_waddr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              stale
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q,  state_d;
    logic [ADDR_W-1:0]   idx_q,    idx_d;
    logic [ADDR_W-1:0]   raddr_q,  raddr_d;
    logic                valid_q,  valid_d;
    logic [ADDR_W-1:0]   index_q,  index_d;
    logic [DATA_W-1:0]   data_q,   data_d;
    logic                stale_q,  stale_d;
    logic                w_snoop_hit;

    // A write at or below idx lands on a register that is captured already
    // (in READ the capture happens on the same edge, so the old value wins).
    assign w_snoop_hit = rf_we && (rf_waddr != '0) && (rf_waddr <= idx_q) &&
                         ((state_q == READ) || (state_q == PRESENT));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        raddr_d = raddr_q;
        valid_d = valid_q;
        index_d = index_q;
        data_d  = data_q;
        stale_d = stale_q | w_snoop_hit;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    raddr_d = '0;
                    stale_d = 1'b0;
                    state_d = READ;
                end
            end
            READ: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    data_d  = rf_read_data;
                    index_d = idx_q;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        raddr_d = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            raddr_q <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            raddr_q <= raddr_d;
            valid_q <= valid_d;
            index_q <= index_d;
            data_q  <= data_d;
            stale_q <= stale_d;
        end
    end

    // The read address register only reloads when entering READ, so it
    // equals idx there and holds its last value everywhere else.
    assign rf_read_addr = raddr_q;
    assign out_valid    = valid_q;
    assign out_index    = index_q;
    assign out_data     = data_q;
    assign stale        = stale_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_dump_reader
//  Brief    : Scoreboard bench for regfile_dump_reader with a register file
//             model, directed dump scenarios and randomized traffic.
//  Revision : 1.0
// ============================================================================
module tb_regfile_dump_reader;

    localparam int N = 32;

    logic        clock = 1'b0;
    logic        reset, start, abort, out_ready, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_read_addr, out_index;
    logic [31:0] rf_read_data, out_data;
    logic        out_valid, busy, done, stale;

    always #5 clock = ~clock;

    regfile_dump_reader #(.NUM_REGS(N), .DATA_W(32), .ADDR_W(5)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data),
        .busy(busy), .done(done), .stale(stale)
    );

    logic [31:0] rf_mem [0:N-1];
    assign rf_read_data = rf_mem[rf_read_addr];

    typedef struct packed { logic [4:0] idx; logic [31:0] data; } beat_t;
    typedef struct packed { logic [7:0] id; logic [31:0] act; logic [31:0] exp; } dchk_t;
    beat_t exp_q[$];
    dchk_t dq[$];

    // Reference model: a dump in progress, the beat number k, whether beat k
    // is on the bus, and whether the dump has just finished.
    bit m_run = 0, m_shown = 0, m_fin = 0, m_stale = 0;
    int m_k = 0, m_addr = 0;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) rf_mem[i] <= '0;
            m_run = 0; m_shown = 0; m_fin = 0; m_stale = 0; m_k = 0; m_addr = 0;
            exp_q.delete();
        end else begin
            if (rf_we && rf_waddr != 0 && m_run && !m_fin && int'(rf_waddr) <= m_k)
                m_stale = 1;
            if (!m_run) begin
                if (start) begin
                    m_run = 1; m_shown = 0; m_fin = 0; m_k = 0; m_addr = 0; m_stale = 0;
                    exp_q.delete();
                end
            end else if (abort) begin
                m_run = 0; m_shown = 0; m_fin = 0;
                exp_q.delete();
            end else if (m_fin) begin
                m_run = 0; m_fin = 0;
            end else if (!m_shown) begin
                exp_q.push_back(beat_t'{idx: 5'(m_k), data: rf_mem[m_k]});
                m_shown = 1;
            end else if (out_ready) begin
                m_shown = 0;
                if (m_k == N - 1) m_fin = 1;
                else begin
                    m_k = m_k + 1;
                    m_addr = m_k;
                end
            end
            if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
        end
    end

    int n_vec = 0, n_bad = 0, beat_cnt = 0;
    bit mon_en = 0;
    logic [31:0] beat_data [0:N-1];

    function automatic string dname(input logic [7:0] id);
        case (id)
            8'd1:  return "reset_outputs";
            8'd2:  return "done_cycle";
            8'd3:  return "done_width";
            8'd4:  return "beat_count";
            8'd5:  return "beat11_data";
            8'd6:  return "beat22_data";
            8'd7:  return "stale_flag";
            8'd8:  return "hold_stable";
            8'd9:  return "beat20_data";
            8'd10: return "beat7_data";
            8'd11: return "abort_outputs";
            8'd12: return "restart_index";
            8'd13: return "wait_timeout";
            default: return "check";
        endcase
    endfunction

    task automatic rep(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, a, e);
        end
    endtask

    // Monitor: drains directed checks, compares control outputs with the
    // model every cycle and pops the scoreboard on each handshake.
    always @(negedge clock) begin
        dchk_t d;
        beat_t b;
        if (mon_en) begin
            while (dq.size() > 0) begin
                d = dq.pop_front();
                rep(dname(d.id), 64'(d.act), 64'(d.exp));
            end
            rep("ctrl{valid,busy,done,stale,raddr}",
                64'({out_valid, busy, done, stale, rf_read_addr}),
                64'({m_shown, m_run, m_fin, m_stale, 5'(m_addr)}));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    rep("beat_unexpected", 64'(out_index), 64'hFFFF);
                end else begin
                    b = exp_q[0];
                    rep("beat{index,data}", 64'({out_index, out_data}), 64'({b.idx, b.data}));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        beat_cnt++;
                        beat_data[out_index] = out_data;
                    end
                end
            end
        end
    end

    task automatic expect_eq(input int id, input logic [31:0] a, input logic [31:0] e);
        dq.push_back(dchk_t'{id: 8'(id), act: a, exp: e});
    endtask

    task automatic drive(input bit s, input bit a, input bit rdy, input bit we,
                         input logic [4:0] wa, input logic [31:0] wd);
        start = s; abort = a; out_ready = rdy; rf_we = we; rf_waddr = wa; rf_wdata = wd;
        @(posedge clock);
        #2;
    endtask

    task automatic wait_beat(input int idx);
        int n = 0;
        while (!(out_valid && int'(out_index) == idx) && n < 300) begin
            drive(0, 0, 1, 0, 0, 0);
            n++;
        end
        if (n >= 300) expect_eq(13, 1, 0);
    endtask

    task automatic run_to_done(output int n);
        n = 0;
        while (!done && n < 300) begin
            drive(0, 0, 1, 0, 0, 0);
            n++;
        end
        if (n >= 300) expect_eq(13, 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, b0;
        logic [4:0]  hold_idx;
        logic [31:0] hold_dat;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        mon_en = 1;
        expect_eq(1, {out_valid, busy, done, stale, rf_read_addr, out_index}, 0);
        expect_eq(1, out_data, 0);
        reset = 1'b0;

        // Preload: R11 and R22 marked, everything else zero.
        for (int i = 0; i < N; i++)
            drive(0, 0, 0, 1, 5'(i), (i == 11) ? 32'hFFFF : (i == 22) ? 32'hEEEE : 32'h0);

        // Full dump with the sink always ready.
        b0 = beat_cnt;
        drive(1, 0, 1, 0, 0, 0);
        n = 1;
        while (!done && n < 200) begin
            drive(0, 0, 1, 0, 0, 0);
            n++;
        end
        expect_eq(2, n, 65);
        drive(0, 0, 1, 0, 0, 0);
        expect_eq(3, done, 0);
        expect_eq(4, beat_cnt - b0, 32);
        expect_eq(5, beat_data[11], 32'h0000FFFF);
        expect_eq(6, beat_data[22], 32'h0000EEEE);
        expect_eq(7, stale, 0);

        // Back-pressure on beat 3 for five cycles.
        b0 = beat_cnt;
        drive(1, 0, 1, 0, 0, 0);
        wait_beat(3);
        hold_idx = out_index; hold_dat = out_data;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            expect_eq(8, {27'd0, out_index}, {27'd0, hold_idx});
            expect_eq(8, out_data, hold_dat);
            expect_eq(8, out_valid, 1);
        end
        run_to_done(n);
        drive(0, 0, 0, 0, 0, 0);
        expect_eq(4, beat_cnt - b0, 32);

        // Write to an already-streamed register during beat 10.
        drive(1, 0, 1, 0, 0, 0);
        wait_beat(10);
        drive(0, 0, 0, 1, 5'd5, 32'h1234);
        run_to_done(n);
        drive(0, 0, 0, 0, 0, 0);
        expect_eq(7, stale, 1);

        // Write to a not-yet-streamed register during beat 10.
        drive(1, 0, 1, 0, 0, 0);
        wait_beat(10);
        drive(0, 0, 0, 1, 5'd20, 32'h5A5A0020);
        run_to_done(n);
        drive(0, 0, 0, 0, 0, 0);
        expect_eq(7, stale, 0);
        expect_eq(9, beat_data[20], 32'h5A5A0020);

        // Write R7 on the same edge that captures it.
        drive(1, 0, 1, 0, 0, 0);
        wait_beat(6);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 1, 5'd7, 32'hABCD);
        run_to_done(n);
        drive(0, 0, 0, 0, 0, 0);
        expect_eq(10, beat_data[7], 32'h0);
        expect_eq(7, stale, 1);

        // Abort at beat 15 after a stale-causing write; then restart.
        drive(1, 0, 1, 0, 0, 0);
        wait_beat(10);
        drive(0, 0, 0, 1, 5'd3, 32'h77);
        wait_beat(15);
        drive(0, 1, 0, 0, 0, 0);
        expect_eq(11, {out_valid, done, busy}, 0);
        expect_eq(7, stale, 1);
        drive(0, 0, 0, 0, 0, 0);
        expect_eq(11, done, 0);
        drive(1, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        expect_eq(12, {out_valid, 3'd0, out_index}, {1'b1, 3'd0, 5'd0});
        run_to_done(n);
        drive(0, 0, 0, 0, 0, 0);

        // Reset during beat 4 with start held, then start immediately after.
        drive(1, 0, 1, 0, 0, 0);
        wait_beat(4);
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        expect_eq(1, {out_valid, busy, done, stale, rf_read_addr, out_index}, 0);
        expect_eq(1, out_data, 0);
        drive(1, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        expect_eq(12, {out_valid, 3'd0, out_index}, {1'b1, 3'd0, 5'd0});
        run_to_done(n);
        drive(0, 0, 0, 0, 0, 0);

        // Randomized traffic: stalls, snooped writes, stray starts, aborts.
        for (int r = 0; r < 8; r++) begin
            drive(1, 0, 1, 0, 0, 0);
            n = 0;
            while (busy && !done && n < 400) begin
                if ($urandom_range(0, 99) < 2)
                    drive(0, 1, 0, 0, 0, 0);
                else
                    drive($urandom_range(0, 7) == 0, 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) == 0, 5'($urandom_range(0, N - 1)), $urandom);
                n++;
            end
            if (n >= 400) expect_eq(13, 1, 0);
            drive(0, 0, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0, 0);
        end

        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
